rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: HOLD_MAX, 16, maximum consecutive cycles one requester may hold a grant; legal range 2..255.
REQ-002 Port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: REQ  input  4  request lines; bit i = requester i.
REQ-005 Port: DONE  input  1  current owner releases grant.
REQ-006 Port: GNT  output  4  one-hot grant; all-zero when no owner.
REQ-007 Port: Q  output  2  encoded index of current owner; 0 when no owner.
REQ-008 Port: V  output  1  grant valid; equals OR of GNT.
REQ-009 Port: EXP  output  1  one-cycle pulse, grant revoked by hold timeout.

Function
REQ-010 The block SHALL implement two states, IDLE and BUSY, plus a 2-bit last-owner pointer LAST and an 8-bit hold counter CNT.
REQ-011 In IDLE with REQ = 0, the block SHALL remain in IDLE with GNT = 0, V = 0, and Q = 0.
REQ-012 In IDLE with REQ != 0, the block SHALL select the first set bit searching LAST+1, LAST+2, LAST+3, LAST (mod 4), and on the next edge SHALL enter BUSY with:
- GNT one-hot for the winner
- Q = winner index
- V = 1
- LAST = winner
- CNT = 0
REQ-013 Grant latency SHALL be exactly one cycle from a sampled request in IDLE to GNT asserted.
REQ-014 In BUSY, CNT SHALL increment by 1 per cycle, saturating at HOLD_MAX-1.
REQ-015 In BUSY, the grant SHALL end on the edge where any of the following is true, returning to IDLE with GNT = 0, V = 0, and Q = 0:
- DONE = 1
- the owner's REQ bit = 0
- CNT = HOLD_MAX-1
REQ-016 When the grant ends only because CNT = HOLD_MAX-1 (DONE = 0 and the owner's REQ bit still 1), EXP SHALL be 1 for exactly the first IDLE cycle; otherwise EXP SHALL be 0.
REQ-017 After any grant ends, the block SHALL spend exactly one IDLE cycle with V = 0 before the next grant (one dead cycle between owners).
REQ-018 Non-owner REQ changes during BUSY SHALL NOT affect GNT, Q, or CNT.
REQ-019 With all four requesters continuously asserting and DONE pulsed every grant, grants SHALL rotate 0,1,2,3,0,...
REQ-020 A requester that times out SHALL become lowest priority (LAST = its index), so other pending requesters win next.
REQ-021 If DONE = 1 in IDLE, it SHALL be ignored.
REQ-022 GNT SHALL never have more than one bit set; Q and V SHALL always be consistent with GNT.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 When RST = 1 at a rising edge, the block SHALL enter IDLE with GNT = 0, Q = 0, V = 0, EXP = 0, CNT = 0, and LAST = 3 (requester 0 has highest priority first).
REQ-025 RST asserted during BUSY SHALL drop the grant on that edge without EXP; RST SHALL take precedence over all other inputs.

Verification
REQ-026 Reset then REQ = 4'b1010 -> one cycle later GNT = 4'b0010, Q = 1, V = 1.
REQ-027 REQ = 4'b1111 held, DONE pulsed 1 cycle after each grant -> owner sequence Q = 0,1,2,3,0 with one V = 0 cycle between each grant.
REQ-028 HOLD_MAX = 4, REQ = 4'b0001 held, DONE = 0 -> V = 1 for 4 cycles, then V = 0 with EXP = 1 for one cycle, then GNT = 4'b0001 re-granted.
REQ-029 HOLD_MAX = 4, REQ = 4'b0011 held, DONE = 0 -> owner 0 times out, next owner is 1 (Q = 1), not 0.
REQ-030 Owner 2 granted, REQ drops to 4'b0000 -> GNT = 0 next edge, EXP = 0; DONE pulse in IDLE -> no change.
REQ-031 RST pulsed mid-grant with REQ = 4'b1111 held -> GNT = 0, EXP = 0 after reset; next grant goes to requester 0.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle for the 4-way round-robin arbiter.
// master drives requests, slave (the arbiter) drives the grant side.
interface rr_arbiter4_if;
  logic [3:0] REQ;
  logic       DONE;
  logic [3:0] GNT;
  logic [1:0] Q;
  logic       V;
  logic       EXP;

  modport master (
    output REQ,
    output DONE,
    input  GNT,
    input  Q,
    input  V,
    input  EXP
  );

  modport slave (
    input  REQ,
    input  DONE,
    output GNT,
    output Q,
    output V,
    output EXP
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold timeout.
// One dead IDLE cycle separates consecutive owners.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 16
) (
  input  logic          CLK,
  input  logic          RST,
  rr_arbiter4_if.slave  bus
);

  localparam logic [7:0] CNT_MAX = 8'(HOLD_MAX - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [7:0] cnt;
  logic [3:0] gnt;
  logic [1:0] q;
  logic       v;
  logic       expd;

  logic [1:0] pick;
  logic       pick_ok;
  logic       own_req;
  logic       at_max;
  logic       fin;
  logic       tmo;

  // Search last+1 .. last+4; descending loop lets the nearest hit win.
  always_comb begin
    pick_ok = 1'b0;
    pick    = last;
    for (int i = 4; i >= 1; i--) begin
      if (bus.REQ[2'(last + 2'(i))]) begin
        pick_ok = 1'b1;
        pick    = 2'(last + 2'(i));
      end
    end
  end

  assign own_req = bus.REQ[q];
  assign at_max  = (cnt == CNT_MAX);
  assign fin     = bus.DONE | ~own_req | at_max;
  assign tmo     = at_max & ~bus.DONE & own_req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      last  <= 2'd3;
      cnt   <= 8'd0;
      gnt   <= 4'b0000;
      q     <= 2'd0;
      v     <= 1'b0;
      expd  <= 1'b0;
    end else begin
      expd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            state <= BUSY;
            gnt   <= 4'b0001 << pick;
            q     <= pick;
            v     <= 1'b1;
            last  <= pick;
            cnt   <= 8'd0;
          end
        end
        BUSY: begin
          if (fin) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            q     <= 2'd0;
            v     <= 1'b0;
            expd  <= tmo;
          end else if (!at_max) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT = gnt;
  assign bus.Q   = q;
  assign bus.V   = v;
  assign bus.EXP = expd;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (HOLD_MAX = 4).
// Vector table plus timeout-rotation sequence and invariant monitor.
module tb_rr_arbiter4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] q;
    logic       v;
    logic       ex;
  } vec_t;

  vec_t tbl[$];
  int   pass_n = 0;
  int   total_n = 0;
  bit   mon_on = 1'b0;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic d,
                              logic [3:0] g, logic [1:0] qq,
                              logic vv, logic e);
    vec_t t;
    t.rst = r; t.req = rq; t.done = d;
    t.gnt = g; t.q = qq; t.v = vv; t.ex = e;
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] want);
    total_n++;
    if (act === want) pass_n++;
    else $display("FAIL %s: got {gnt,q,v,exp}=%b want %b", nm, act, want);
  endtask

  task automatic step(logic r, logic [3:0] rq, logic d);
    RST = r;
    bus.REQ = rq;
    bus.DONE = d;
    @(posedge CLK);
    #1;
  endtask

  // Structural invariants, sampled mid-cycle.
  always @(negedge CLK) begin
    if (mon_on) begin
      logic [1:0] eq;
      logic [7:0] want;
      eq = 2'd0;
      for (int i = 0; i < 4; i++) if (bus.GNT[i]) eq = 2'(i);
      want = {bus.GNT, eq, |bus.GNT, bus.EXP};
      if ($countones(bus.GNT) > 1) want[7:4] = 4'b0000;
      chk("invariant", {bus.GNT, bus.Q, bus.V, bus.EXP}, want);
    end
  end

  initial begin
    bus.REQ = 4'b0000;
    bus.DONE = 1'b0;

    // reset, then REQ=1010 -> requester 1
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1010, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1010, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
    // rotation 0,1,2,3,0 with DONE pulses
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b1000, 3, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0));
    // single requester timeout and re-grant
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 4'b0001, 0, 1, 0));
    // timeout demotes owner 0; owner 1 next
    tbl.push_back(mk(1, 4'b0011, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0011, 0, 4'b0010, 1, 1, 0));
    // owner 2, non-owner churn, request drop, DONE in IDLE
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 1, 4'b1000, 3, 1, 0));
    tbl.push_back(mk(0, 4'b1000, 1, 4'b0000, 0, 0, 0));
    // reset mid-grant, including on the timeout edge
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].done);
      if (i == 0) mon_on = 1'b1;
      chk($sformatf("vec%0d", i),
          {bus.GNT, bus.Q, bus.V, bus.EXP},
          {tbl[i].gnt, tbl[i].q, tbl[i].v, tbl[i].ex});
    end

    // All four hold forever: each owner times out, rotation continues.
    step(1, 4'b1111, 0);
    for (int g = 0; g < 6; g++) begin
      logic [1:0] own;
      own = 2'(g % 4);
      for (int c = 0; c < 4; c++) begin
        step(0, 4'b1111, 0);
        chk($sformatf("tmo_rot%0d_c%0d", g, c),
            {bus.GNT, bus.Q, bus.V, bus.EXP},
            {4'b0001 << own, own, 1'b1, 1'b0});
      end
      step(0, 4'b1111, 0);
      chk($sformatf("tmo_rot%0d_exp", g),
          {bus.GNT, bus.Q, bus.V, bus.EXP}, 8'b0000_00_0_1);
    end

    // Owner drops request on the timeout edge: no EXP.
    step(1, 4'b0000, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);
    step(0, 4'b0010, 0);
    chk("own_grant", {bus.GNT, bus.Q, bus.V, bus.EXP}, 8'b0010_01_1_0);
    step(0, 4'b0000, 0);
    chk("drop_at_max", {bus.GNT, bus.Q, bus.V, bus.EXP}, 8'b0000_00_0_0);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
